tl_a_narrow_128to64: RTL and testbench

- Downstream consumer of the 2-entry TileLink A-channel queue.
- Takes 128-bit A-channel beats and re-emits them as 64-bit beats for the narrow memory-side port.
- Data-bearing beats are split into low-half then high-half; all other fields are held per wide beat.
- Registered, one-entry skid so the queue's io_deq_ready never depends combinationally on io_out_ready when idle.

---
 rtl/tl_a_narrow_128to64_pkg.sv | 61 ++++++
 rtl/tl_a_narrow_128to64_if.sv | 60 ++++++
 rtl/tl_a_narrow_128to64_beat_counter.sv | 51 +++++
 rtl/tl_a_narrow_128to64.sv | 110 +++++++++++
 tb/tb_tl_a_narrow_128to64.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/tl_a_narrow_128to64_pkg.sv
// =============================================================================
// tl_pkg: shared TileLink A-channel types, opcodes and beat-count helpers.
// Revision: 1.0
// =============================================================================
`default_nettype none

package tl_pkg;

    localparam int TL_IN_W   = 128;
    localparam int TL_OUT_W  = 64;
    localparam int TL_ADDR_W = 32;
    localparam int TL_SRC_W  = 5;
    localparam int TL_CNT_W  = 4;

    localparam logic [2:0] PUT_FULL    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL = 3'd1;
    localparam logic [2:0] ARITH       = 3'd2;
    localparam logic [2:0] LOGICAL     = 3'd3;
    localparam logic [2:0] GET         = 3'd4;
    localparam logic [2:0] HINT        = 3'd5;

    typedef struct packed {
        logic [2:0]           opcode;
        logic [2:0]           param;
        logic [3:0]           size;
        logic [TL_SRC_W-1:0]  source;
        logic [TL_ADDR_W-1:0] address;
        logic [TL_IN_W-1:0]   data;
        logic                 corrupt;
    } tl_a_beat_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LO    = 2'd1,
        ST_HI    = 2'd2
    } narrow_state_e;

    function automatic logic is_data_op(input logic [2:0] op);
        return op inside {PUT_FULL, PUT_PARTIAL, ARITH, LOGICAL};
    endfunction

    // Wide (16 B) beats in a transaction, minus one; sizes above 256 B are illegal upstream.
    function automatic logic [TL_CNT_W-1:0] wide_beats_m1(input logic [2:0] op,
                                                          input logic [3:0] size);
        logic [TL_CNT_W-1:0] r;
        r = '0;
        if (is_data_op(op)) begin
            case (size)
                4'd5:    r = 4'd1;
                4'd6:    r = 4'd3;
                4'd7:    r = 4'd7;
                4'd8:    r = 4'd15;
                default: r = 4'd0;
            endcase
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tl_a_narrow_128to64_if.sv
// =============================================================================
// tl_a_narrow_128to64_if: wide-in / narrow-out A-channel bundle.
// Revision: 1.0
// =============================================================================
`default_nettype none

interface tl_a_narrow_128to64_if
    import tl_pkg::*;
#(
    parameter int IN_W   = TL_IN_W,
    parameter int OUT_W  = TL_OUT_W,
    parameter int ADDR_W = TL_ADDR_W,
    parameter int SRC_W  = TL_SRC_W
);
    logic              io_in_valid;
    logic              io_in_ready;
    logic [2:0]        io_in_bits_opcode;
    logic [2:0]        io_in_bits_param;
    logic [3:0]        io_in_bits_size;
    logic [SRC_W-1:0]  io_in_bits_source;
    logic [ADDR_W-1:0] io_in_bits_address;
    logic [IN_W-1:0]   io_in_bits_data;
    logic              io_in_bits_corrupt;

    logic              io_out_valid;
    logic              io_out_ready;
    logic [2:0]        io_out_bits_opcode;
    logic [2:0]        io_out_bits_param;
    logic [3:0]        io_out_bits_size;
    logic [SRC_W-1:0]  io_out_bits_source;
    logic [ADDR_W-1:0] io_out_bits_address;
    logic [OUT_W-1:0]  io_out_bits_data;
    logic              io_out_bits_corrupt;
    logic              io_out_last;

    // Narrower view: consumes the wide channel, produces the narrow one.
    modport slave (
        input  io_in_valid, io_in_bits_opcode, io_in_bits_param, io_in_bits_size,
               io_in_bits_source, io_in_bits_address, io_in_bits_data, io_in_bits_corrupt,
               io_out_ready,
        output io_in_ready,
               io_out_valid, io_out_bits_opcode, io_out_bits_param, io_out_bits_size,
               io_out_bits_source, io_out_bits_address, io_out_bits_data,
               io_out_bits_corrupt, io_out_last
    );

    // Environment view: upstream queue plus downstream memory port.
    modport master (
        output io_in_valid, io_in_bits_opcode, io_in_bits_param, io_in_bits_size,
               io_in_bits_source, io_in_bits_address, io_in_bits_data, io_in_bits_corrupt,
               io_out_ready,
        input  io_in_ready,
               io_out_valid, io_out_bits_opcode, io_out_bits_param, io_out_bits_size,
               io_out_bits_source, io_out_bits_address, io_out_bits_data,
               io_out_bits_corrupt, io_out_last
    );

endinterface

`default_nettype wire

// File: rtl/tl_a_narrow_128to64_beat_counter.sv
// =============================================================================
// tl_beat_counter: tracks wide beats remaining in a transaction; flags first/last.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tl_beat_counter
    import tl_pkg::*;
(
    input  wire logic                clock,
    input  wire logic                reset,
    input  wire logic                in_fire,
    input  wire logic                beat_done,
    input  wire logic [TL_CNT_W-1:0] load_val,
    output logic                     first,
    output logic                     last
);
    logic [TL_CNT_W-1:0] cnt;
    logic                first_q;
    logic                first_eff;
    logic [TL_CNT_W-1:0] cnt_eff;

    // cnt is the number of wide beats still to come after the one currently held.
    always_comb begin
        first_eff = first_q;
        cnt_eff   = cnt;
        if (beat_done) begin
            first_eff = (cnt == '0);
            cnt_eff   = (cnt == '0) ? '0 : cnt - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt     <= '0;
            first_q <= 1'b1;
        end else if (in_fire) begin
            cnt     <= first_eff ? load_val : cnt_eff;
            first_q <= 1'b0;
        end else begin
            cnt     <= cnt_eff;
            first_q <= first_eff;
        end
    end

    assign first = first_q;
    assign last  = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/tl_a_narrow_128to64.sv
// =============================================================================
// tl_a_narrow_128to64: splits 128-bit TileLink A beats into 64-bit beats.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tl_a_narrow_128to64
    import tl_pkg::*;
#(
    parameter int IN_W   = 128,
    parameter int OUT_W  = 64,
    parameter int ADDR_W = 32,
    parameter int SRC_W  = 5
) (
    input  wire logic              clock,
    input  wire logic              reset,
    tl_a_narrow_128to64_if.slave   io
);
    narrow_state_e state;
    tl_a_beat_t    hold;

    logic in_fire;
    logic out_fire;
    logic beat_done;
    logic data_op;
    logic split;
    logic cnt_first;
    logic cnt_last;
    logic [TL_CNT_W-1:0] load_val;

    assign data_op   = is_data_op(hold.opcode);
    assign split     = data_op && (hold.size >= 4'd4);
    assign out_fire  = (state != ST_EMPTY) && io.io_out_ready;
    assign beat_done = out_fire && ((state == ST_HI) || ((state == ST_LO) && !split));

    // Ready looks at out_ready only when a beat is finishing; an empty stage is always ready.
    assign io.io_in_ready = (state == ST_EMPTY) || beat_done;
    assign in_fire        = io.io_in_valid && io.io_in_ready;
    assign load_val       = wide_beats_m1(io.io_in_bits_opcode, io.io_in_bits_size);

    tl_beat_counter u_beat_counter (
        .clock     (clock),
        .reset     (reset),
        .in_fire   (in_fire),
        .beat_done (beat_done),
        .load_val  (load_val),
        .first     (cnt_first),
        .last      (cnt_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            if (in_fire) begin
                state <= ST_LO;
            end else if ((state == ST_LO) && out_fire && split) begin
                state <= ST_HI;
            end else if (beat_done) begin
                state <= ST_EMPTY;
            end
        end
    end

    // Holding register has no reset: it is only observed while state != EMPTY.
    always_ff @(posedge clock) begin
        if (in_fire) begin
            hold.opcode  <= io.io_in_bits_opcode;
            hold.param   <= io.io_in_bits_param;
            hold.size    <= io.io_in_bits_size;
            hold.source  <= io.io_in_bits_source;
            hold.address <= io.io_in_bits_address;
            hold.data    <= io.io_in_bits_data;
            hold.corrupt <= io.io_in_bits_corrupt;
        end
    end

    always_comb begin
        io.io_out_bits_data = '0;
        if (data_op) begin
            if (state == ST_HI) begin
                io.io_out_bits_data = hold.data[IN_W-1:OUT_W];
            end else if (split) begin
                io.io_out_bits_data = hold.data[OUT_W-1:0];
            end else begin
                io.io_out_bits_data = hold.address[3] ? hold.data[IN_W-1:OUT_W]
                                                      : hold.data[OUT_W-1:0];
            end
        end
    end

    assign io.io_out_valid        = (state != ST_EMPTY);
    assign io.io_out_bits_opcode  = hold.opcode;
    assign io.io_out_bits_param   = hold.param;
    assign io.io_out_bits_size    = hold.size;
    assign io.io_out_bits_source  = hold.source[SRC_W-1:0];
    assign io.io_out_bits_address = hold.address[ADDR_W-1:0];
    assign io.io_out_bits_corrupt = hold.corrupt;

    // cnt_first only matters for the next incoming beat; last reflects the held beat.
    assign io.io_out_last = (state != ST_EMPTY) &&
                            (!data_op ||
                             (((state == ST_HI) || ((state == ST_LO) && !split)) && cnt_last));

    logic unused_ok;
    assign unused_ok = cnt_first;

endmodule

`default_nettype wire

// File: tb/tb_tl_a_narrow_128to64.sv
// =============================================================================
// tb_tl_a_narrow_128to64: directed self-checking bench for the A-channel narrower.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_tl_a_narrow_128to64;
    import tl_pkg::*;

    logic clock;
    logic reset;
    int   tests;
    int   fails;

    tl_a_narrow_128to64_if bus ();

    tl_a_narrow_128to64 dut (
        .clock (clock),
        .reset (reset),
        .io    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected $finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [2:0] op, input logic [3:0] sz,
                           input logic [31:0] addr, input logic [127:0] d);
        bus.io_in_valid        = 1'b1;
        bus.io_in_bits_opcode  = op;
        bus.io_in_bits_param   = 3'd0;
        bus.io_in_bits_size    = sz;
        bus.io_in_bits_source  = 5'h0B;
        bus.io_in_bits_address = addr;
        bus.io_in_bits_data    = d;
        bus.io_in_bits_corrupt = 1'b0;
    endtask

    initial begin
        logic [127:0] d;
        int nb;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.io_out_ready = 1'b1;
        present(GET, 4'd0, 32'h0, 128'h0);
        bus.io_in_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_out_valid", bus.io_out_valid, 1'b0);
        check("rst_out_last",  bus.io_out_last,  1'b0);
        check("rst_in_ready",  bus.io_in_ready,  1'b1);

        // Get: one narrow beat, data forced to zero
        present(GET, 4'd6, 32'h1000, {64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0002});
        tick();
        bus.io_in_valid = 1'b0;
        check("get_valid", bus.io_out_valid, 1'b1);
        check("get_data",  bus.io_out_bits_data, 64'h0);
        check("get_last",  bus.io_out_last, 1'b1);
        check("get_addr",  bus.io_out_bits_address, 32'h1000);
        check("get_op",    bus.io_out_bits_opcode, GET);
        tick();
        check("get_done_valid", bus.io_out_valid, 1'b0);
        check("get_in_ready",   bus.io_in_ready, 1'b1);

        // PutFull size 4: low half then high half
        present(PUT_FULL, 4'd4, 32'h1100, {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555});
        tick();
        bus.io_in_valid = 1'b0;
        check("pf4_lo_data",  bus.io_out_bits_data, 64'h5555_5555_5555_5555);
        check("pf4_lo_last",  bus.io_out_last, 1'b0);
        check("pf4_lo_ready", bus.io_in_ready, 1'b0);
        tick();
        check("pf4_hi_data",  bus.io_out_bits_data, 64'hAAAA_AAAA_AAAA_AAAA);
        check("pf4_hi_last",  bus.io_out_last, 1'b1);
        check("pf4_hi_valid", bus.io_out_valid, 1'b1);
        tick();
        check("pf4_end_valid", bus.io_out_valid, 1'b0);

        // PutFull size 6 streamed: 8 narrow beats, no bubble
        present(PUT_FULL, 4'd6, 32'h3000, {64'd1, 64'd0});
        tick();
        present(PUT_FULL, 4'd6, 32'h3000, {64'd3, 64'd2});
        for (int n = 0; n < 8; n++) begin
            check($sformatf("str_valid_%0d", n), bus.io_out_valid, 1'b1);
            check($sformatf("str_data_%0d", n),  bus.io_out_bits_data, 64'(n));
            check($sformatf("str_last_%0d", n),  bus.io_out_last, (n == 7) ? 1'b1 : 1'b0);
            check($sformatf("str_src_%0d", n),   bus.io_out_bits_source, 5'h0B);
            check($sformatf("str_rdy_%0d", n),   bus.io_in_ready, (n % 2 == 1) ? 1'b1 : 1'b0);
            tick();
            if (n % 2 == 1) begin
                nb = (n + 3) / 2;
                if (nb < 4) present(PUT_FULL, 4'd6, 32'h3000, {64'(2 * nb + 1), 64'(2 * nb)});
                else bus.io_in_valid = 1'b0;
            end
        end
        check("str_end_valid", bus.io_out_valid, 1'b0);

        // PutPartial size 3: half chosen by address bit 3
        d = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
        present(PUT_PARTIAL, 4'd3, 32'h2008, d);
        tick();
        bus.io_in_valid = 1'b0;
        check("pp_hi_data", bus.io_out_bits_data, 64'h1111_2222_3333_4444);
        check("pp_hi_last", bus.io_out_last, 1'b1);
        tick();
        present(PUT_PARTIAL, 4'd3, 32'h2000, d);
        tick();
        bus.io_in_valid = 1'b0;
        check("pp_lo_data", bus.io_out_bits_data, 64'h5555_6666_7777_8888);
        check("pp_lo_last", bus.io_out_last, 1'b1);
        tick();
        check("pp_end_valid", bus.io_out_valid, 1'b0);

        // Backpressure in LO for 5 cycles
        bus.io_out_ready = 1'b0;
        present(PUT_FULL, 4'd4, 32'h5000, {64'hCAFE_0000_0000_00FF, 64'h0BAD_0000_0000_0011});
        tick();
        bus.io_in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valid_%0d", i), bus.io_out_valid, 1'b1);
            check($sformatf("bp_data_%0d", i),  bus.io_out_bits_data, 64'h0BAD_0000_0000_0011);
            check($sformatf("bp_rdy_%0d", i),   bus.io_in_ready, 1'b0);
            tick();
        end
        bus.io_out_ready = 1'b1;
        check("bp_lo_data", bus.io_out_bits_data, 64'h0BAD_0000_0000_0011);
        check("bp_lo_last", bus.io_out_last, 1'b0);
        tick();
        check("bp_hi_data", bus.io_out_bits_data, 64'hCAFE_0000_0000_00FF);
        check("bp_hi_last", bus.io_out_last, 1'b1);
        tick();
        check("bp_end_valid", bus.io_out_valid, 1'b0);

        // Input stall between wide beats of one size-5 transaction
        present(PUT_FULL, 4'd5, 32'h4000, {64'hA1, 64'hA0});
        tick();
        bus.io_in_valid = 1'b0;
        check("stl_a_lo_last", bus.io_out_last, 1'b0);
        tick();
        check("stl_a_hi_data", bus.io_out_bits_data, 64'hA1);
        check("stl_a_hi_last", bus.io_out_last, 1'b0);
        tick();
        check("stl_gap_valid", bus.io_out_valid, 1'b0);
        tick();
        present(PUT_FULL, 4'd5, 32'h4000, {64'hB1, 64'hB0});
        tick();
        bus.io_in_valid = 1'b0;
        check("stl_b_lo_data", bus.io_out_bits_data, 64'hB0);
        check("stl_b_lo_last", bus.io_out_last, 1'b0);
        tick();
        check("stl_b_hi_last", bus.io_out_last, 1'b1);
        tick();

        // Reset while in HI of a multi-beat burst
        present(PUT_FULL, 4'd6, 32'h6000, {64'hE1, 64'hE0});
        tick();
        bus.io_in_valid = 1'b0;
        tick();
        check("rmb_in_hi_data", bus.io_out_bits_data, 64'hE1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rmb_out_valid", bus.io_out_valid, 1'b0);
        check("rmb_in_ready",  bus.io_in_ready, 1'b1);
        check("rmb_out_last",  bus.io_out_last, 1'b0);
        present(PUT_FULL, 4'd4, 32'h7000, {64'hF1, 64'hF0});
        tick();
        bus.io_in_valid = 1'b0;
        check("rmb_p_lo_last", bus.io_out_last, 1'b0);
        tick();
        check("rmb_p_hi_data", bus.io_out_bits_data, 64'hF1);
        check("rmb_p_hi_last", bus.io_out_last, 1'b1);
        tick();
        check("rmb_end_valid", bus.io_out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
